// File: rtl/load_writeback.sv
// load_writeback: final pipeline stage of the 16-bit CPU, feeding the 8x16
// register file write port.
//
// Accepts one retiring operation per in_valid/in_ready handshake:
//   - ALU writes (kind 00) reach the register file one cycle after acceptance.
//   - Word/byte loads (kind 01/10) issue a single memory read and write back
//     the word or the selected byte (replicated on both lanes) after mem_ack.
//   - Kind 11 retires without any writeback.
// The outstanding destination is exported so decode can stall on load-use.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready high only in IDLE)
//   in_kind, in_dest, in_data  operation kind, destination, ALU result/address
//   in_hb, in_lb               byte lane enables for the destination
//   mem_req, mem_addr          read request (held until ack), word address
//   mem_ack, mem_rdata         read acknowledge and data
//   wb_we, wb_dest, wb_data    register file write port
//   wb_hb, wb_lb               register file byte lane enables
//   pend_valid, pend_dest      destination of the not-yet-committed write
//   err_misalign               one-cycle pulse for a dropped odd word load
module load_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [2:0]  in_dest,
    input  logic [15:0] in_data,
    input  logic        in_hb,
    input  logic        in_lb,
    output logic        mem_req,
    output logic [14:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        wb_we,
    output logic [2:0]  wb_dest,
    output logic [15:0] wb_data,
    output logic        wb_hb,
    output logic        wb_lb,
    output logic        pend_valid,
    output logic [2:0]  pend_dest,
    output logic        err_misalign
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEM  = 1'b1;

    localparam logic [1:0] KIND_ALU = 2'b00;
    localparam logic [1:0] KIND_LDW = 2'b01;
    localparam logic [1:0] KIND_LDB = 2'b10;

    logic [0:0]  state, state_next;

    // Context of the load in flight, captured at acceptance.
    logic [2:0]  ld_dest, ld_dest_next;
    logic        ld_byte, ld_byte_next;
    logic        ld_sel, ld_sel_next;
    logic        ld_hb, ld_hb_next;
    logic        ld_lb, ld_lb_next;

    logic        req_next;
    logic [14:0] addr_next;
    logic        we_next;
    logic [2:0]  dest_next;
    logic [15:0] data_next;
    logic        hb_next;
    logic        lb_next;
    logic        err_next;
    logic        pend_valid_next;
    logic [2:0]  pend_dest_next;

    logic        accept;
    logic [7:0]  sel_byte;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Little-endian byte select: odd byte address picks the high byte.
    assign sel_byte = ld_sel ? mem_rdata[15:8] : mem_rdata[7:0];

    // Next-state decode. wb_we and err_misalign default low so they are
    // single-cycle pulses; the remaining write-port fields simply hold.
    always_comb begin
        state_next   = state;
        ld_dest_next = ld_dest;
        ld_byte_next = ld_byte;
        ld_sel_next  = ld_sel;
        ld_hb_next   = ld_hb;
        ld_lb_next   = ld_lb;
        req_next     = mem_req;
        addr_next    = mem_addr;
        we_next      = 1'b0;
        dest_next    = wb_dest;
        data_next    = wb_data;
        hb_next      = wb_hb;
        lb_next      = wb_lb;
        err_next     = 1'b0;

        if (state == IDLE) begin
            if (accept) begin
                case (in_kind)
                    KIND_ALU: begin
                        we_next   = in_hb | in_lb;
                        dest_next = in_dest;
                        data_next = in_data;
                        hb_next   = in_hb;
                        lb_next   = in_lb;
                    end
                    KIND_LDW: begin
                        if (in_data[0]) begin
                            err_next = 1'b1;
                        end else begin
                            req_next     = 1'b1;
                            addr_next    = in_data[15:1];
                            state_next   = MEM;
                            ld_dest_next = in_dest;
                            ld_byte_next = 1'b0;
                        end
                    end
                    KIND_LDB: begin
                        req_next     = 1'b1;
                        addr_next    = in_data[15:1];
                        state_next   = MEM;
                        ld_dest_next = in_dest;
                        ld_byte_next = 1'b1;
                        ld_sel_next  = in_data[0];
                        ld_hb_next   = in_hb;
                        ld_lb_next   = in_lb;
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            // mem_ack is only meaningful here; request drops on the ack edge.
            if (mem_ack) begin
                req_next   = 1'b0;
                state_next = IDLE;
                dest_next  = ld_dest;
                if (ld_byte) begin
                    we_next   = ld_hb | ld_lb;
                    data_next = {sel_byte, sel_byte};
                    hb_next   = ld_hb;
                    lb_next   = ld_lb;
                end else begin
                    we_next   = 1'b1;
                    data_next = mem_rdata;
                    hb_next   = 1'b1;
                    lb_next   = 1'b1;
                end
            end
        end

        // Pending write: either a load still waiting in MEM or a write
        // being presented to the register file this cycle.
        pend_valid_next = (state_next == MEM) | we_next;
        if (state_next == MEM) begin
            pend_dest_next = ld_dest_next;
        end else if (we_next) begin
            pend_dest_next = dest_next;
        end else begin
            pend_dest_next = 3'd0;
        end
    end

    // All outputs except in_ready are registered; reset discards any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ld_dest      <= 3'd0;
            ld_byte      <= 1'b0;
            ld_sel       <= 1'b0;
            ld_hb        <= 1'b0;
            ld_lb        <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= 15'd0;
            wb_we        <= 1'b0;
            wb_dest      <= 3'd0;
            wb_data      <= 16'd0;
            wb_hb        <= 1'b0;
            wb_lb        <= 1'b0;
            err_misalign <= 1'b0;
            pend_valid   <= 1'b0;
            pend_dest    <= 3'd0;
        end else begin
            state        <= state_next;
            ld_dest      <= ld_dest_next;
            ld_byte      <= ld_byte_next;
            ld_sel       <= ld_sel_next;
            ld_hb        <= ld_hb_next;
            ld_lb        <= ld_lb_next;
            mem_req      <= req_next;
            mem_addr     <= addr_next;
            wb_we        <= we_next;
            wb_dest      <= dest_next;
            wb_data      <= data_next;
            wb_hb        <= hb_next;
            wb_lb        <= lb_next;
            err_misalign <= err_next;
            pend_valid   <= pend_valid_next;
            pend_dest    <= pend_dest_next;
        end
    end

endmodule
